cram_readback: RTL and testbench

CRAM_READBACK -- requirements
Module: cram_readback

---
 rtl/cram_readback_if.sv | 25 ++
 rtl/cram_readback.sv | 118 +++++++++++
 tb/tb_cram_readback.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_readback_if.sv
// Bridge read port plus PSRAM user read port of the CRAM readback engine.
// master: the bus/PSRAM environment; slave: the readback engine.
interface cram_readback_if #(
  parameter int ADDRESS_BITS = 16
);
  logic [31:0]             br_addr;
  logic                    br_rd;
  logic [31:0]             br_rd_data;
  logic                    br_rd_valid;
  logic                    busy;
  logic [ADDRESS_BITS-1:0] mem_rd_address;
  logic                    mem_rd_en;
  logic                    mem_rd_ack;
  logic [7:0]              mem_rd_data;

  modport master (
    output br_addr, br_rd, mem_rd_ack, mem_rd_data,
    input  br_rd_data, br_rd_valid, busy, mem_rd_address, mem_rd_en
  );

  modport slave (
    input  br_addr, br_rd, mem_rd_ack, mem_rd_data,
    output br_rd_data, br_rd_valid, busy, mem_rd_address, mem_rd_en
  );
endinterface

// File: rtl/cram_readback.sv
// CRAM readback engine: turns one bridge word read into four PSRAM byte
// reads and returns the bytes packed big-endian.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for an in-window bridge read
// ISSUE   | strobe the PSRAM for byte idx, or zero-fill it past the window
// WAIT    | waiting for mem_rd_ack of byte idx; down-counter bounds the wait
// DONE    | one-cycle br_rd_valid, then back to IDLE
module cram_readback #(
  parameter logic [31:0] ADDR_FROM      = 32'h0002_0000,
  parameter logic [31:0] ADDR_TO        = 32'h0002_bfff,
  parameter int          ADDRESS_BITS   = 16,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  cram_readback_if.slave   bus,
  output logic             err_timeout,
  output logic             err_overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_TC   = TW'(1);

  logic [1:0]    state;
  logic [1:0]    idx;
  logic [31:0]   base;
  logic [31:0]   word;
  logic [TW-1:0] tmr;

  logic [31:0]   byte_addr;
  logic          byte_in_window;
  logic          req_in_window;
  logic [4:0]    lane_msb;
  logic          last_byte;

  // Bridge address of the byte currently being fetched, and window checks.
  always_comb begin
    byte_addr      = ADDR_FROM + base + {30'd0, idx};
    byte_in_window = (byte_addr <= ADDR_TO);
    req_in_window  = (bus.br_addr >= ADDR_FROM) && (bus.br_addr <= ADDR_TO);
    // Byte k lands in bits [31-8k -: 8]; 31-8k is just {~k, 3'b111}.
    lane_msb       = {~idx, 3'b111};
    last_byte      = (idx == 2'd3);
  end

  assign bus.mem_rd_en      = (state == S_ISSUE) && byte_in_window;
  assign bus.mem_rd_address = ADDRESS_BITS'(base + {30'd0, idx});
  assign bus.br_rd_valid    = (state == S_DONE);
  assign bus.busy           = (state != S_IDLE);
  assign bus.br_rd_data     = word;

  // Sequencer: accept, fetch four bytes one at a time, report, sticky errors.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      base        <= 32'd0;
      word        <= 32'd0;
      tmr         <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (bus.br_rd && (state != S_IDLE)) begin
        err_overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.br_rd && req_in_window) begin
            base  <= (bus.br_addr - ADDR_FROM) & 32'hffff_fffc;
            idx   <= 2'd0;
            word  <= 32'd0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (byte_in_window) begin
            tmr   <= TMR_LOAD;
            state <= S_WAIT;
          end else begin
            // Past the window end: zero-fill without touching the PSRAM.
            word[lane_msb -: 8] <= 8'h00;
            idx   <= idx + 2'd1;
            state <= last_byte ? S_DONE : S_ISSUE;
          end
        end
        S_WAIT: begin
          if (bus.mem_rd_ack) begin
            word[lane_msb -: 8] <= bus.mem_rd_data;
            idx   <= idx + 2'd1;
            state <= last_byte ? S_DONE : S_ISSUE;
          end else if (tmr == TMR_TC) begin
            word[lane_msb -: 8] <= 8'hff;
            err_timeout <= 1'b1;
            idx   <= idx + 2'd1;
            state <= last_byte ? S_DONE : S_ISSUE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cram_readback.sv
// Bench for cram_readback: two instances (full window and a window ending
// at 0x0002bffd), a latency-configurable PSRAM model, and a scoreboard of
// expected strobes and words checked as the DUT produces them.
module tb_cram_readback;

  localparam logic [31:0] FROM  = 32'h0002_0000;
  localparam logic [31:0] TO_0  = 32'h0002_bfff;
  localparam logic [31:0] TO_1  = 32'h0002_bffd;
  localparam int          TMO   = 64;

  typedef struct packed {
    int          inst;
    logic [15:0] addr;
    int          cyc;
  } strobe_t;

  typedef struct packed {
    int          inst;
    logic [31:0] word;
    int          cyc;
  } word_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_chk;
  int   n_err;

  logic        br_rd_s   [2];
  logic [31:0] br_addr_s [2];
  logic        ack_s     [2];
  logic [7:0]  rdata_s   [2];

  logic        en_w    [2];
  logic [15:0] addr_w  [2];
  logic        valid_w [2];
  logic        busy_w  [2];
  logic [31:0] data_w  [2];
  logic        terr_w  [2];
  logic        oerr_w  [2];

  int   lat      [2];
  logic drop_en  [2];
  int   drop_idx [2];
  logic model_ready;

  logic        pend  [2];
  int          cnt   [2];
  logic [15:0] pa    [2];
  logic        prev_en [2];

  strobe_t sq[$];
  word_t   wq[$];

  cram_readback_if #(.ADDRESS_BITS(16)) bus0 ();
  cram_readback_if #(.ADDRESS_BITS(16)) bus1 ();

  cram_readback #(.ADDR_FROM(FROM), .ADDR_TO(TO_0), .ADDRESS_BITS(16), .TIMEOUT_CYCLES(TMO)) u_dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus0),
    .err_timeout (terr_w[0]),
    .err_overrun (oerr_w[0])
  );

  cram_readback #(.ADDR_FROM(FROM), .ADDR_TO(TO_1), .ADDRESS_BITS(16), .TIMEOUT_CYCLES(TMO)) u_dut1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus1),
    .err_timeout (terr_w[1]),
    .err_overrun (oerr_w[1])
  );

  assign bus0.br_rd       = br_rd_s[0];
  assign bus0.br_addr     = br_addr_s[0];
  assign bus0.mem_rd_ack  = ack_s[0];
  assign bus0.mem_rd_data = rdata_s[0];
  assign bus1.br_rd       = br_rd_s[1];
  assign bus1.br_addr     = br_addr_s[1];
  assign bus1.mem_rd_ack  = ack_s[1];
  assign bus1.mem_rd_data = rdata_s[1];

  assign en_w[0]    = bus0.mem_rd_en;
  assign addr_w[0]  = bus0.mem_rd_address;
  assign valid_w[0] = bus0.br_rd_valid;
  assign busy_w[0]  = bus0.busy;
  assign data_w[0]  = bus0.br_rd_data;
  assign en_w[1]    = bus1.mem_rd_en;
  assign addr_w[1]  = bus1.mem_rd_address;
  assign valid_w[1] = bus1.br_rd_valid;
  assign busy_w[1]  = bus1.busy;
  assign data_w[1]  = bus1.br_rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'd0:   return 8'h11;
      16'd1:   return 8'h22;
      16'd2:   return 8'h33;
      16'd3:   return 8'h44;
      default: return a[7:0] ^ a[15:8] ^ 8'ha5;
    endcase
  endfunction

  // PSRAM model: acks lat cycles after each strobe; keeps running across a
  // DUT reset so a late ack can reach an engine that has already abandoned it.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      ack_s[g] <= 1'b0;
      if (!model_ready) begin
        pend[g]    <= 1'b0;
        cnt[g]     <= 0;
        pa[g]      <= 16'd0;
        rdata_s[g] <= 8'h00;
      end else if (en_w[g]) begin
        if (drop_en[g] && (int'(addr_w[g][1:0]) == drop_idx[g])) begin
          pend[g] <= 1'b0;
        end else if (lat[g] == 1) begin
          ack_s[g]   <= 1'b1;
          rdata_s[g] <= mem_byte(addr_w[g]);
          pend[g]    <= 1'b0;
        end else begin
          pend[g] <= 1'b1;
          cnt[g]  <= lat[g] - 1;
          pa[g]   <= addr_w[g];
        end
      end else if (pend[g]) begin
        if (cnt[g] == 1) begin
          ack_s[g]   <= 1'b1;
          rdata_s[g] <= mem_byte(pa[g]);
          pend[g]    <= 1'b0;
        end else begin
          cnt[g] <= cnt[g] - 1;
        end
      end
    end
  end

  // Monitor: every strobe and every valid must match the head of its queue.
  always @(negedge clk) begin : mon
    strobe_t s;
    word_t   w;
    for (int g = 0; g < 2; g++) begin
      if (en_w[g]) begin
        check_val("strobe_b2b", {31'd0, prev_en[g]}, 32'd0);
        if (sq.size() == 0) begin
          check_val("strobe_unexpected", {31'd0, en_w[g]}, 32'd0);
        end else begin
          s = sq.pop_front();
          check_val("strobe_inst", g, s.inst);
          check_val("strobe_addr", {16'd0, addr_w[g]}, {16'd0, s.addr});
          check_val("strobe_cycle", cyc, s.cyc);
        end
      end
      if (valid_w[g]) begin
        check_val("busy_at_valid", {31'd0, busy_w[g]}, 32'd1);
        if (wq.size() == 0) begin
          check_val("valid_unexpected", {31'd0, valid_w[g]}, 32'd0);
        end else begin
          w = wq.pop_front();
          check_val("word_inst", g, w.inst);
          check_val("word_data", data_w[g], w.word);
          check_val("word_cycle", cyc, w.cyc);
        end
      end
      prev_en[g] <= en_w[g];
    end
  end

  // Drive one bridge read and push what an independent model expects of it.
  task automatic issue(input int g, input logic [31:0] addr);
    logic [31:0] to_a, base, off, wexp;
    logic [7:0]  b;
    int          t;
    strobe_t     s;
    word_t       w;
    to_a = (g == 0) ? TO_0 : TO_1;
    br_addr_s[g] = addr;
    br_rd_s[g]   = 1'b1;
    if (addr >= FROM && addr <= to_a) begin
      base = (addr - FROM) & 32'hffff_fffc;
      t    = cyc + 1;
      wexp = 32'd0;
      for (int k = 0; k < 4; k++) begin
        off = base + k;
        if (FROM + off <= to_a) begin
          s.inst = g; s.addr = off[15:0]; s.cyc = t;
          sq.push_back(s);
          if (drop_en[g] && k == drop_idx[g]) begin
            b = 8'hff;
            t = t + TMO + 1;
          end else begin
            b = mem_byte(off[15:0]);
            t = t + lat[g] + 1;
          end
        end else begin
          b = 8'h00;
          t = t + 1;
        end
        wexp[31-8*k -: 8] = b;
      end
      w.inst = g; w.word = wexp; w.cyc = t;
      wq.push_back(w);
    end
    @(negedge clk);
    br_rd_s[g] = 1'b0;
  endtask

  task automatic pulse_raw(input int g, input logic [31:0] addr);
    br_addr_s[g] = addr;
    br_rd_s[g]   = 1'b1;
    @(negedge clk);
    br_rd_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int n;
    n = 0;
    while ((busy_w[g] || wq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_busy", {31'd0, busy_w[g]}, 32'd0);
    check_val("drain_words", wq.size(), 32'd0);
    check_val("drain_strobes", sq.size(), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_data"},  data_w[0], 32'd0);
    check_val({tag, "_addr"},  {16'd0, addr_w[0]}, 32'd0);
    check_val({tag, "_en"},    {31'd0, en_w[0]}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, valid_w[0]}, 32'd0);
    check_val({tag, "_busy"},  {31'd0, busy_w[0]}, 32'd0);
    check_val({tag, "_terr"},  {31'd0, terr_w[0]}, 32'd0);
    check_val({tag, "_oerr"},  {31'd0, oerr_w[0]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    model_ready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      br_rd_s[g] = 1'b0; br_addr_s[g] = 32'd0;
      lat[g] = 1; drop_en[g] = 1'b0; drop_idx[g] = 0;
    end
    repeat (3) @(negedge clk);
    model_ready = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("rst");
    check_val("rst_busy1", {31'd0, busy_w[1]}, 32'd0);

    lat[0] = 1; issue(0, 32'h0002_0000); wait_done(0, 100);
    lat[0] = 2; issue(0, 32'h0002_0006); wait_done(0, 100);
    lat[0] = 3; issue(0, 32'h0002_bffe); wait_done(0, 100);
    lat[1] = 1; issue(1, 32'h0002_bffc); wait_done(1, 100);
    check_val("short_low16", {16'd0, data_w[1][15:0]}, 32'd0);
    check_val("terr_before", {31'd0, terr_w[0]}, 32'd0);

    lat[0] = 1; drop_en[0] = 1'b1; drop_idx[0] = 2;
    issue(0, 32'h0002_0010); wait_done(0, 300);
    drop_en[0] = 1'b0;
    check_val("terr_after", {31'd0, terr_w[0]}, 32'd1);
    check_val("oerr_before", {31'd0, oerr_w[0]}, 32'd0);

    lat[0] = 4; issue(0, 32'h0002_0020);
    @(negedge clk);
    pulse_raw(0, 32'h0002_0100);
    wait_done(0, 100);
    check_val("oerr_after", {31'd0, oerr_w[0]}, 32'd1);

    issue(0, 32'h0001_0000);
    check_val("oor_busy", {31'd0, busy_w[0]}, 32'd0);
    repeat (20) @(negedge clk);

    lat[0] = 6; issue(0, 32'h0002_0030);
    repeat (2) @(negedge clk);
    check_val("pre_rst_busy", {31'd0, busy_w[0]}, 32'd1);
    reset_n = 1'b0;
    sq.delete();
    wq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check_reset_state("midrst");

    lat[0] = 1; issue(0, 32'h0002_0004); wait_done(0, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
